if_fetch_unit: RTL and testbench

//  Instruction-fetch stage. Owns the PC and issues requests to instruction memory

---
 rtl/if_fetch_unit_if.sv | 24 ++
 rtl/if_fetch_unit.sv | 88 ++++++++
 tb/tb_if_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack handshake, IF/ID presentation,
// and the ID-stall / EX-redirect controls that steer the fetch unit.
interface if_fetch_unit_if;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemRdata;
    logic [31:0] PCPlus4;
    logic [31:0] Instruction;
    logic        InstValid;

    modport master (
        input  Stall, Redirect, RedirectPC, MemAck, MemRdata,
        output MemReq, MemAddr, PCPlus4, Instruction, InstValid
    );

    modport slave (
        output Stall, Redirect, RedirectPC, MemAck, MemRdata,
        input  MemReq, MemAddr, PCPlus4, Instruction, InstValid
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the memory req/ack handshake and
// presents PCPlus4/Instruction/InstValid to the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] inst_reg, inst_nx;
    logic [31:0] drain_addr, drain_nx;
    logic [31:0] target;

    assign target = {bus.RedirectPC[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst_reg   <= NOP_INST;
            drain_addr <= RESET_PC;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            inst_reg   <= inst_nx;
            drain_addr <= drain_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        pc_nx           = pc;
        inst_nx         = inst_reg;
        drain_nx        = drain_addr;
        bus.MemReq      = 1'b0;
        bus.MemAddr     = pc;
        bus.PCPlus4     = pc + 32'd4;
        bus.InstValid   = 1'b0;
        bus.Instruction = NOP_INST;

        case (state)
            IDLE: begin
                state_nx = REQ;
                if (bus.Redirect) pc_nx = target;
            end
            REQ: begin
                bus.MemReq = 1'b1;
                if (bus.Redirect) begin
                    pc_nx = target;
                    // Unacked request must stay open on its original address.
                    if (!bus.MemAck) begin
                        drain_nx = pc;
                        state_nx = DRAIN;
                    end
                end else if (bus.MemAck) begin
                    inst_nx  = bus.MemRdata;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                bus.InstValid   = 1'b1;
                bus.Instruction = inst_reg;
                if (bus.Redirect) begin
                    pc_nx    = target;
                    inst_nx  = NOP_INST;
                    state_nx = REQ;
                end else if (!bus.Stall) begin
                    pc_nx    = pc + 32'd4;
                    state_nx = REQ;
                end
            end
            DRAIN: begin
                bus.MemReq  = 1'b1;
                bus.MemAddr = drain_addr;
                if (bus.Redirect) pc_nx = target;
                if (bus.MemAck) state_nx = REQ;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a transaction-level fetch model checked
// every cycle, plus hand-computed literal expectations for key scenarios.
module tb_if_fetch_unit;

    logic clk;
    logic rst;
    logic rst1;
    int   lat0;
    int   wcnt0;
    int   n_chk;
    int   n_fail;

    if_fetch_unit_if b0();
    if_fetch_unit_if b1();

    if_fetch_unit u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    if_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC),
        .NOP_INST (32'h0000_0013)
    ) u1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h2001_0005;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory for u0: acks after lat0 wait cycles (0 = same cycle as request).
    always @(posedge clk or posedge rst) begin
        if (rst) wcnt0 <= 0;
        else if (b0.MemReq && !b0.MemAck) wcnt0 <= wcnt0 + 1;
        else wcnt0 <= 0;
    end
    assign b0.MemAck   = b0.MemReq && (wcnt0 >= lat0);
    assign b0.MemRdata = memf(b0.MemAddr);

    // Memory for u1: zero-wait, no hazards.
    assign b1.MemAck     = b1.MemReq;
    assign b1.MemRdata   = memf(b1.MemAddr);
    assign b1.Stall      = 1'b0;
    assign b1.Redirect   = 1'b0;
    assign b1.RedirectPC = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of u0: a fetch is either not yet started, holding a
    // word for IF/ID, or waiting on memory (possibly a wrong-path request).
    logic        m_started = 1'b0;
    logic        m_have    = 1'b0;
    logic        m_discard = 1'b0;
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] m_word    = 32'h0;
    logic [31:0] m_old     = 32'h0;

    initial begin
        logic [31:0] tgt;
        logic        e_valid;
        logic        e_req;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_started = 1'b0;
                m_have    = 1'b0;
                m_discard = 1'b0;
                m_pc      = 32'h0;
                m_word    = 32'h0;
                m_old     = 32'h0;
            end
            e_valid = m_started && m_have;
            e_req   = m_started && !m_have;
            chk("m_valid", 32'(b0.InstValid), 32'(e_valid));
            chk("m_req", 32'(b0.MemReq), 32'(e_req));
            chk("m_inst", b0.Instruction, e_valid ? m_word : 32'h0);
            chk("m_pc4", b0.PCPlus4, m_pc + 32'd4);
            if (e_req) chk("m_addr", b0.MemAddr, m_discard ? m_old : m_pc);
            if (!rst) begin
                tgt = b0.RedirectPC & 32'hFFFF_FFFC;
                if (!m_started) begin
                    m_started = 1'b1;
                    if (b0.Redirect) m_pc = tgt;
                end else if (m_have) begin
                    if (b0.Redirect) begin
                        m_have = 1'b0;
                        m_pc   = tgt;
                    end else if (!b0.Stall) begin
                        m_have = 1'b0;
                        m_pc   = m_pc + 32'd4;
                    end
                end else if (b0.Redirect) begin
                    if (b0.MemAck) begin
                        m_discard = 1'b0;
                    end else begin
                        if (!m_discard) m_old = m_pc;
                        m_discard = 1'b1;
                    end
                    m_pc = tgt;
                end else if (b0.MemAck) begin
                    if (m_discard) m_discard = 1'b0;
                    else begin
                        m_have = 1'b1;
                        m_word = b0.MemRdata;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst1 = 1'b1; lat0 = 0;
        b0.Stall = 1'b0; b0.Redirect = 1'b0; b0.RedirectPC = 32'h0;
        repeat (2) tick();
        chk("rst_req", 32'(b0.MemReq), 32'd0);
        chk("rst_valid", 32'(b0.InstValid), 32'd0);
        chk("rst_inst", b0.Instruction, 32'h0);
        chk("rst_pc4", b0.PCPlus4, 32'h4);
        rst = 1'b0;
        chk("idle_req", 32'(b0.MemReq), 32'd0);

        // Single-cycle memory at address 0
        tick();
        chk("t1_req", 32'(b0.MemReq), 32'd1);
        chk("t1_addr", b0.MemAddr, 32'h0);
        tick();
        chk("t1_valid", 32'(b0.InstValid), 32'd1);
        chk("t1_inst", b0.Instruction, 32'h2001_0005);
        chk("t1_pc4", b0.PCPlus4, 32'h4);
        tick();
        chk("t1_next_addr", b0.MemAddr, 32'h4);

        // Three-cycle memory latency
        lat0 = 2;
        for (int i = 0; i < 3; i++) begin
            chk("t2_addr", b0.MemAddr, 32'h4);
            chk("t2_req", 32'(b0.MemReq), 32'd1);
            chk("t2_valid", 32'(b0.InstValid), 32'd0);
            tick();
        end

        // Stall held in HOLD
        b0.Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_inst", b0.Instruction, 32'h0004_FFFB);
            chk("t3_pc4", b0.PCPlus4, 32'h8);
            chk("t3_valid", 32'(b0.InstValid), 32'd1);
            chk("t3_req", 32'(b0.MemReq), 32'd0);
            tick();
        end
        chk("t3_still_valid", 32'(b0.InstValid), 32'd1);
        b0.Stall = 1'b0;
        tick();
        chk("t3_next_addr", b0.MemAddr, 32'h8);

        // Redirect during REQ without ack; ack two cycles later is discarded
        b0.Redirect = 1'b1; b0.RedirectPC = 32'h40;
        tick();
        b0.Redirect = 1'b0;
        chk("t4_drain_addr", b0.MemAddr, 32'h8);
        chk("t4_drain_req", 32'(b0.MemReq), 32'd1);
        chk("t4_drain_pc4", b0.PCPlus4, 32'h44);
        tick();
        chk("t4_ack_addr", b0.MemAddr, 32'h8);
        chk("t4_ack", 32'(b0.MemAck), 32'd1);
        chk("t4_no_valid", 32'(b0.InstValid), 32'd0);
        tick();
        chk("t4_new_addr", b0.MemAddr, 32'h40);
        chk("t4_no_valid2", 32'(b0.InstValid), 32'd0);
        lat0 = 0;
        tick();
        chk("t4_inst", b0.Instruction, 32'h0040_FFBF);
        chk("t4_pc4", b0.PCPlus4, 32'h44);

        // Redirect to unaligned target while stalled in HOLD
        b0.Stall = 1'b1; b0.Redirect = 1'b1; b0.RedirectPC = 32'h83;
        tick();
        b0.Stall = 1'b0; b0.Redirect = 1'b0;
        chk("t5_valid", 32'(b0.InstValid), 32'd0);
        chk("t5_addr", b0.MemAddr, 32'h80);
        chk("t5_pc4", b0.PCPlus4, 32'h84);
        tick();
        chk("t5_inst", b0.Instruction, 32'h0080_FF7F);
        tick();
        chk("t5_next_addr", b0.MemAddr, 32'h84);

        // Redirect coinciding with ack in REQ: word dropped, refetch at target
        b0.Redirect = 1'b1; b0.RedirectPC = 32'h100;
        tick();
        b0.Redirect = 1'b0;
        chk("rq_addr", b0.MemAddr, 32'h100);
        chk("rq_valid", 32'(b0.InstValid), 32'd0);
        tick();
        chk("rq_inst", b0.Instruction, 32'h0100_FEFF);
        chk("rq_pc4", b0.PCPlus4, 32'h104);
        tick();

        // Repeated redirects while draining; last one wins
        lat0 = 3; b0.Redirect = 1'b1; b0.RedirectPC = 32'h200;
        tick();
        chk("dr_addr1", b0.MemAddr, 32'h104);
        chk("dr_pc4_1", b0.PCPlus4, 32'h204);
        b0.RedirectPC = 32'h300;
        tick();
        chk("dr_addr2", b0.MemAddr, 32'h104);
        chk("dr_pc4_2", b0.PCPlus4, 32'h304);
        lat0 = 2; b0.RedirectPC = 32'h400;
        tick();
        b0.Redirect = 1'b0; lat0 = 0;
        chk("dr_addr3", b0.MemAddr, 32'h400);

        // Mixed stall/latency stretch, model-checked only
        for (int i = 0; i < 12; i++) begin
            b0.Stall = (i % 3 == 1);
            lat0 = i % 2;
            tick();
        end

        // Reset asserted mid-DRAIN, then redirect while IDLE
        b0.Stall = 1'b0; lat0 = 5;
        repeat (2) tick();
        b0.Redirect = 1'b1; b0.RedirectPC = 32'h600;
        tick();
        b0.Redirect = 1'b0;
        chk("rd_req", 32'(b0.MemReq), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("rd_rst_req", 32'(b0.MemReq), 32'd0);
        chk("rd_rst_valid", 32'(b0.InstValid), 32'd0);
        chk("rd_rst_inst", b0.Instruction, 32'h0);
        chk("rd_rst_pc4", b0.PCPlus4, 32'h4);
        tick();
        lat0 = 0; b0.Redirect = 1'b1; b0.RedirectPC = 32'h503; rst = 1'b0;
        tick();
        b0.Redirect = 1'b0;
        chk("idle_redir_addr", b0.MemAddr, 32'h500);
        repeat (3) tick();

        // Reset PC at top of address space
        chk("w_rst_pc4", b1.PCPlus4, 32'h0);
        chk("w_rst_inst", b1.Instruction, 32'h0000_0013);
        chk("w_rst_req", 32'(b1.MemReq), 32'd0);
        rst1 = 1'b0;
        tick();
        chk("w_addr", b1.MemAddr, 32'hFFFF_FFFC);
        chk("w_req", 32'(b1.MemReq), 32'd1);
        tick();
        chk("w_valid", 32'(b1.InstValid), 32'd1);
        chk("w_inst", b1.Instruction, 32'hFFFC_0003);
        chk("w_pc4", b1.PCPlus4, 32'h0);
        tick();
        chk("w_next_addr", b1.MemAddr, 32'h0);
        chk("w_next_pc4", b1.PCPlus4, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
